// File: rtl/chinx_clkdiv_pkg.sv
// Shared types, reset defaults and config legalisation for the clock divider.
package chinx_clkdiv_pkg;

    localparam int CLKDIV_CNT_W = 32;

    localparam logic [CLKDIV_CNT_W-1:0] CLKDIV_DEF_PERIOD = CLKDIV_CNT_W'(1001);
    localparam logic [CLKDIV_CNT_W-1:0] CLKDIV_DEF_HIGH   = CLKDIV_CNT_W'(501);

    // One channel's configuration: enable, period and high-phase length.
    typedef struct packed {
        logic                    en;
        logic [CLKDIV_CNT_W-1:0] period;
        logic [CLKDIV_CNT_W-1:0] high;
    } clkdiv_cfg_t;

    // Clamp a raw configuration into a usable one: period at least 2,
    // high never longer than the period.
    function automatic clkdiv_cfg_t legalise(input clkdiv_cfg_t c);
        clkdiv_cfg_t r;
        r = c;
        if (r.period < CLKDIV_CNT_W'(2)) begin
            r.period = CLKDIV_CNT_W'(2);
        end
        if (r.high > r.period) begin
            r.high = r.period;
        end
        return r;
    endfunction

endpackage

// File: rtl/chinx_clkdiv_ch.sv
// One divider channel: counter, active/shadow configuration, pending flag
// and registered level plus rise/fall ticks.
module chinx_clkdiv_ch
    import chinx_clkdiv_pkg::*;
#(
    parameter logic [CLKDIV_CNT_W-1:0] DEF_PERIOD = CLKDIV_DEF_PERIOD,
    parameter logic [CLKDIV_CNT_W-1:0] DEF_HIGH   = CLKDIV_DEF_HIGH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  clkdiv_cfg_t wr_cfg,
    output logic        pend,
    output logic        div,
    output logic        rise,
    output logic        fall
);

    localparam clkdiv_cfg_t RST_CFG =
        legalise('{en: 1'b1, period: DEF_PERIOD, high: DEF_HIGH});
    localparam logic [CLKDIV_CNT_W-1:0] RST_THR = RST_CFG.period - RST_CFG.high;
    localparam logic [CLKDIV_CNT_W-1:0] ONE     = CLKDIV_CNT_W'(1);

    logic [CLKDIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [CLKDIV_CNT_W-1:0] thr_q, thr_d;
    clkdiv_cfg_t             act_q, act_d;
    clkdiv_cfg_t             shd_q, shd_d;
    logic                    pend_q, pend_d;
    logic                    div_q, div_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;

    clkdiv_cfg_t             nxt_cfg;
    logic                    wrap;
    logic                    apply;

    // Next-state: count/wrap, apply shadow at period boundary (or at once when
    // disabled), then derive the level from the post-edge count and threshold.
    always_comb begin
        nxt_cfg = legalise(shd_q);
        wrap    = act_q.en && (cnt_q == (act_q.period - ONE));
        apply   = pend_q && (wrap || !act_q.en);

        act_d  = act_q;
        thr_d  = thr_q;
        shd_d  = shd_q;
        pend_d = pend_q;

        if (apply) begin
            act_d = nxt_cfg;
            thr_d = nxt_cfg.period - nxt_cfg.high;
            cnt_d = '0;
        end else if (!act_q.en || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        // A write coinciding with an apply lands in the shadow after the old
        // shadow has been consumed, so the flag stays set for the next wrap.
        if (wr_en) begin
            shd_d  = wr_cfg;
            pend_d = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end

        div_d  = act_d.en && (cnt_d >= thr_d);
        rise_d = div_d && !div_q;
        fall_d = !div_d && div_q;
    end

    // State registers with synchronous reset to the default configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            thr_q  <= RST_THR;
            act_q  <= RST_CFG;
            shd_q  <= RST_CFG;
            pend_q <= 1'b0;
            div_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            thr_q  <= thr_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            div_q  <= div_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign pend = pend_q;
    assign div  = div_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/chinx_clkdiv.sv
// Multi-channel programmable divider: config-write decode and one
// independent chinx_clkdiv_ch per channel. CNT_W is expected to match the
// package counter width, since the channel configuration struct uses it.
module chinx_clkdiv
    import chinx_clkdiv_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = CLKDIV_CNT_W,
    parameter int unsigned DEF_PERIOD = 1001,
    parameter int unsigned DEF_HIGH   = 501,
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] fall_tick
);

    clkdiv_cfg_t wr_cfg;

    assign wr_cfg = {cfg_en, cfg_period, cfg_high};

    // Channel indices only span 0..NUM_CH-1, so a write to any index outside
    // that range matches no channel and is dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic wr_hit;

        assign wr_hit = cfg_we && (32'(cfg_ch) == gi);

        chinx_clkdiv_ch #(
            .DEF_PERIOD (CLKDIV_CNT_W'(DEF_PERIOD)),
            .DEF_HIGH   (CLKDIV_CNT_W'(DEF_HIGH))
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_hit),
            .wr_cfg (wr_cfg),
            .pend   (cfg_pend[gi]),
            .div    (div_out[gi]),
            .rise   (rise_tick[gi]),
            .fall   (fall_tick[gi])
        );
    end

endmodule

// File: tb/tb_chinx_clkdiv.sv
// Bench for chinx_clkdiv: directed scenarios plus random config traffic,
// every cycle compared with a per-channel behavioural model. A 3-channel
// instance shares the inputs so that writes to index 3 must be ignored there.
module tb_chinx_clkdiv;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic        cfg_en = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic [31:0] cfg_high = 32'd0;
    logic [3:0]  cfg_pend, div_out, rise_tick, fall_tick;
    logic [2:0]  pend3, div3, rise3, fall3;

    int checks = 0;
    int failures = 0;

    // Behavioural model state per channel.
    bit          m_en[NCH], s_en[NCH], m_pend[NCH], m_div[NCH], m_rise[NCH], m_fall[NCH];
    int unsigned m_per[NCH], m_high[NCH], m_cnt[NCH], s_per[NCH], s_high[NCH];

    always #5 clk = ~clk;

    chinx_clkdiv u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_pend(cfg_pend),
        .div_out(div_out), .rise_tick(rise_tick), .fall_tick(fall_tick)
    );

    chinx_clkdiv #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_pend(pend3),
        .div_out(div3), .rise_tick(rise3), .fall_tick(fall3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    // Model of one clock edge, from the behavioural rules of the divider.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_en[c] = 1'b1; m_per[c] = 1001; m_high[c] = 501; m_cnt[c] = 0;
                s_en[c] = 1'b1; s_per[c] = 1001; s_high[c] = 501;
                m_pend[c] = 1'b0; m_div[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
            end else begin
                bit at_end, app, lvl;
                at_end = m_en[c] && (m_cnt[c] == m_per[c] - 1);
                app = m_pend[c] && (at_end || !m_en[c]);
                if (app) begin
                    m_en[c]   = s_en[c];
                    m_per[c]  = (s_per[c] < 2) ? 2 : s_per[c];
                    m_high[c] = (s_high[c] > m_per[c]) ? m_per[c] : s_high[c];
                    m_cnt[c]  = 0;
                end else if (m_en[c] && !at_end) begin
                    m_cnt[c] = m_cnt[c] + 1;
                end else begin
                    m_cnt[c] = 0;
                end
                if (cfg_we && (int'(cfg_ch) == c)) begin
                    s_en[c] = cfg_en; s_per[c] = cfg_period; s_high[c] = cfg_high;
                    m_pend[c] = 1'b1;
                end else if (app) begin
                    m_pend[c] = 1'b0;
                end
                lvl = m_en[c] && (m_cnt[c] + m_high[c] >= m_per[c]);
                m_rise[c] = lvl && !m_div[c];
                m_fall[c] = !lvl && m_div[c];
                m_div[c]  = lvl;
            end
        end
    endtask

    // One clock: advance model at the edge, compare all outputs 1 time unit later.
    task automatic step();
        logic [3:0] ep, ed, er, ef;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NCH; c++) begin
            ep[c] = m_pend[c]; ed[c] = m_div[c]; er[c] = m_rise[c]; ef[c] = m_fall[c];
        end
        check_eq("pend", 32'(cfg_pend), 32'(ep));
        check_eq("div", 32'(div_out), 32'(ed));
        check_eq("rise", 32'(rise_tick), 32'(er));
        check_eq("fall", 32'(fall_tick), 32'(ef));
        check_eq("pend3", 32'(pend3), 32'(ep[2:0]));
        check_eq("div3", 32'(div3), 32'(ed[2:0]));
        check_eq("rise3", 32'(rise3), 32'(er[2:0]));
        check_eq("fall3", 32'(fall3), 32'(ef[2:0]));
    endtask

    task automatic wr(input int ch, input bit en, input int unsigned p, input int unsigned h);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_en = en; cfg_period = p; cfg_high = h;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int n;
        int guard;

        // 1: reset state and default waveform on ch0
        rst = 1'b1;
        step();
        check_eq("rst_div", 32'(div_out), 32'd0);
        check_eq("rst_pend", 32'(cfg_pend), 32'd0);
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 1501; k++) begin
            step();
            if (k == 500)  check_eq("t1_rise500", 32'(rise_tick[0]), 32'd1);
            if (k == 1001) check_eq("t1_fall1001", 32'(fall_tick[0]), 32'd1);
            if (k == 1501) check_eq("t1_rise1501", 32'(rise_tick[0]), 32'd1);
            if (k < 1001 && div_out[0]) n++;
        end
        check_eq("t1_high_len", 32'(n), 32'd501);

        // 2: mid-period write on ch1 waits for the wrap
        guard = 0;
        while (m_cnt[1] != 100 && guard < 2000) begin step(); guard++; end
        wr(1, 1'b1, 4, 1);
        check_eq("t2_pend_set", 32'(cfg_pend[1]), 32'd1);
        guard = 0;
        while (m_pend[1] && guard < 2000) begin step(); guard++; end
        check_eq("t2_wait", 32'(guard), 32'd900);
        check_eq("t2_pend_clr", 32'(cfg_pend[1]), 32'd0);
        for (int j = 0; j < 8; j++) begin
            check_eq("t2_pat", 32'(div_out[1]), 32'((j % 4) == 3));
            step();
        end

        // 3: disable ch2, then reprogram while disabled
        wr(2, 1'b0, 10, 5);
        guard = 0;
        while (m_en[2] && guard < 2000) begin step(); guard++; end
        check_eq("t3_off", 32'(div_out[2]), 32'd0);
        wr(2, 1'b1, 10, 5);
        check_eq("t3_pend1", 32'(cfg_pend[2]), 32'd1);
        step();
        check_eq("t3_applied", 32'(cfg_pend[2]), 32'd0);
        n = 0;
        while (!rise_tick[2] && n < 20) begin step(); n++; end
        check_eq("t3_rise_lat", 32'(n), 32'd5);
        step(); n = 1;
        while (!rise_tick[2] && n < 30) begin step(); n++; end
        check_eq("t3_period", 32'(n), 32'd10);

        // 4: legalisation of degenerate configs on ch2
        wr(2, 1'b0, 10, 5);
        guard = 0;
        while (m_en[2] && guard < 50) begin step(); guard++; end
        wr(2, 1'b1, 0, 7);
        n = 0;
        for (int j = 0; j < 30; j++) begin step(); if (rise_tick[2]) n++; end
        check_eq("t4_rises", 32'(n), 32'd1);
        check_eq("t4_high", 32'(div_out[2]), 32'd1);
        wr(2, 1'b1, 6, 0);
        n = 0;
        for (int j = 0; j < 30; j++) begin step(); if (fall_tick[2]) n++; end
        check_eq("t4_falls", 32'(n), 32'd1);
        check_eq("t4_low", 32'(div_out[2]), 32'd0);

        // 5: write landing on ch3's wrap edge
        wr(3, 1'b1, 8, 3);
        guard = 0;
        while (m_pend[3] && guard < 2000) begin step(); guard++; end
        wr(3, 1'b1, 6, 1);
        guard = 0;
        while (m_cnt[3] != 7 && guard < 20) begin step(); guard++; end
        wr(3, 1'b1, 5, 2);
        check_eq("t5_pend_kept", 32'(cfg_pend[3]), 32'd1);
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 5) check_eq("t5_pend_pre", 32'(cfg_pend[3]), 32'd1);
            if (j == 6) check_eq("t5_pend_post", 32'(cfg_pend[3]), 32'd0);
        end

        // 6: reset mid-period with pending writes, then out-of-range write
        wr(0, 1'b1, 7, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_div", 32'(div_out), 32'd0);
        check_eq("t6_rise", 32'(rise_tick), 32'd0);
        check_eq("t6_fall", 32'(fall_tick), 32'd0);
        check_eq("t6_pend", 32'(cfg_pend), 32'd0);
        wr(3, 1'b1, 4, 2);
        check_eq("t6_oob_pend3", 32'(pend3), 32'd0);
        check_eq("t6_pend_ch3", 32'(cfg_pend[3]), 32'd1);
        for (int k = 2; k <= 500; k++) step();
        check_eq("t6_rise500", 32'(rise_tick), 32'hF);

        // random config traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cfg_we     = 1'b1;
                cfg_ch     = 2'($urandom_range(0, 3));
                cfg_en     = ($urandom_range(0, 4) != 0);
                cfg_period = $urandom_range(0, 12);
                cfg_high   = $urandom_range(0, 14);
            end
            step();
            cfg_we = 1'b0;
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
